// File: rtl/angle_servo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : angle_servo_pkg
// Brief    : Shared state encoding, direction constants and state helpers
//            for the angle servo controller.
// Config   : ANGLE_SERVO_HAMMER_EN adds the HAMMER startup state.
// Revision : 1.0 - initial release
// ============================================================================
package angle_servo_pkg;

    localparam logic DIR_FWD = 1'b1;   // drive towards increasing angle
    localparam logic DIR_RVS = 1'b0;   // drive towards decreasing angle

    // Encodings are pinned so a build with or without HAMMER keeps the same
    // values for every other state.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CALC   = 4'd1,
        ACCEL  = 4'd3,
        CRUISE = 4'd4,
        DECEL  = 4'd5,
        RETRY  = 4'd6,
        DONE   = 4'd7,
        FAIL   = 4'd8
`ifdef ANGLE_SERVO_HAMMER_EN
        , HAMMER = 4'd2
`endif
    } state_t;

    // States in which the PWM is actively driving the motor.
    function automatic logic is_run_state(input state_t s);
        return (s == ACCEL) || (s == CRUISE) || (s == DECEL)
`ifdef ANGLE_SERVO_HAMMER_EN
            || (s == HAMMER)
`endif
            ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/angle_wrap_err.sv
`default_nettype none
// ============================================================================
// Module   : angle_wrap_err
// Brief    : Shortest-path angular error on a circle of 2^ANGLE_W counts.
//            The exact half-circle is reported as a forward move.
// Revision : 1.0 - initial release
// ============================================================================
module angle_wrap_err
    import angle_servo_pkg::*;
#(
    parameter int ANGLE_W = 12
) (
    input  logic [ANGLE_W-1:0] target_angle,
    input  logic [ANGLE_W-1:0] current_angle,
    output logic               direction,
    output logic [ANGLE_W-1:0] magnitude
);

    localparam logic [ANGLE_W-1:0] c_half = {1'b1, {(ANGLE_W-1){1'b0}}};

    logic [ANGLE_W-1:0] w_err;

    // Modular difference, then fold the far half back as a reverse move.
    always_comb begin
        w_err = target_angle - current_angle;
        if (w_err <= c_half) begin
            direction = DIR_FWD;
            magnitude = w_err;
        end else begin
            direction = DIR_RVS;
            magnitude = (~w_err) + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/angle_servo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : angle_servo_ctrl
// Brief    : Closed-loop angle servo: ramps a PWM ratio up, cruises, ramps
//            down near the target, with stall detection and bounded retries.
// Config   : ANGLE_SERVO_HAMMER_EN - full-power startup pulses (HAMMER)
//            before the acceleration ramp; hammer_count ignored otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module angle_servo_ctrl
    import angle_servo_pkg::*;
#(
    parameter int ANGLE_W      = 12,
    parameter int RATIO_W      = 8,
    parameter int TOLERANCE    = 2,
    parameter int DECEL_ZONE   = 64,
    parameter int STALL_CYCLES = 50000,
    parameter int MIN_RATIO    = 40,
    parameter int MAX_RATIO    = 240
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [ANGLE_W-1:0] target_angle,
    input  logic [ANGLE_W-1:0] current_angle,
    input  logic               angle_update,
    input  logic               abort_angle,
    input  logic [3:0]         ramp_step,
    input  logic [1:0]         retry_count,
    input  logic [3:0]         hammer_count,
    input  logic               pwm_done,
    output logic               pwm_enable,
    output logic               pwm_update,
    output logic [RATIO_W-1:0] pwm_ratio,
    output logic               pwm_direction,
    output logic               angle_done,
    output logic               startup_fail,
    output logic               run_stall
);

    localparam logic [ANGLE_W-1:0] c_tol        = ANGLE_W'(TOLERANCE);
    localparam logic [ANGLE_W-1:0] c_decel      = ANGLE_W'(DECEL_ZONE);
    localparam logic [RATIO_W-1:0] c_min        = RATIO_W'(MIN_RATIO);
    localparam logic [RATIO_W-1:0] c_max        = RATIO_W'(MAX_RATIO);
    localparam int                 c_stall_w    = $clog2(STALL_CYCLES + 1);
    localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(STALL_CYCLES - 1);
    localparam logic [9:0]         c_retry_last = 10'd1023;

    state_t               r_state, w_state_nx;
    logic [ANGLE_W-1:0]   r_target, w_target_nx;
    logic                 r_dir, w_dir_nx;
    logic [RATIO_W-1:0]   r_ratio, w_ratio_nx;
    logic                 r_upd, w_upd_nx;
    logic                 r_pending, w_pending_nx;
    logic [1:0]           r_retries, w_retries_nx;
    logic [9:0]           r_wait, w_wait_nx;
    logic                 r_sfail, w_sfail_nx;
    logic                 r_rstall, w_rstall_nx;
    logic                 r_ever_moved, w_ever_nx;
    logic [c_stall_w-1:0] r_stall_cnt;
    logic [ANGLE_W-1:0]   r_prev_angle;
`ifdef ANGLE_SERVO_HAMMER_EN
    logic [3:0]           r_hammer_left, w_hammer_nx;
`else
    logic                 w_unused_hammer;
    assign w_unused_hammer = ^hammer_count;
`endif

    logic                 w_err_dir;
    logic [ANGLE_W-1:0]   w_err_mag;
    logic                 w_moved, w_stall, w_can_step;
    logic [RATIO_W:0]     w_step_ext, w_up_sum, w_floor;
    logic [RATIO_W-1:0]   w_ratio_up, w_ratio_dn;

    angle_wrap_err #(.ANGLE_W(ANGLE_W)) u_err (
        .target_angle  (r_target),
        .current_angle (current_angle),
        .direction     (w_err_dir),
        .magnitude     (w_err_mag)
    );

    // A new ratio may be issued once the previous one has been acknowledged.
    assign w_moved    = (current_angle != r_prev_angle);
    assign w_stall    = is_run_state(r_state) && !w_moved && (r_stall_cnt == c_stall_last);
    assign w_can_step = !r_pending || pwm_done;
    assign w_step_ext = {{(RATIO_W-3){1'b0}}, ramp_step};
    assign w_up_sum   = {1'b0, r_ratio} + w_step_ext;
    assign w_floor    = {1'b0, c_min} + w_step_ext;
    assign w_ratio_up = (w_up_sum >= {1'b0, c_max}) ? c_max : w_up_sum[RATIO_W-1:0];
    assign w_ratio_dn = ({1'b0, r_ratio} <= w_floor) ? c_min : (r_ratio - w_step_ext[RATIO_W-1:0]);

    // State and datapath register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_target     <= '0;
            r_dir        <= 1'b0;
            r_ratio      <= '0;
            r_upd        <= 1'b0;
            r_pending    <= 1'b0;
            r_retries    <= '0;
            r_wait       <= '0;
            r_sfail      <= 1'b0;
            r_rstall     <= 1'b0;
            r_ever_moved <= 1'b0;
`ifdef ANGLE_SERVO_HAMMER_EN
            r_hammer_left <= '0;
`endif
        end else begin
            r_state      <= w_state_nx;
            r_target     <= w_target_nx;
            r_dir        <= w_dir_nx;
            r_ratio      <= w_ratio_nx;
            r_upd        <= w_upd_nx;
            r_pending    <= w_pending_nx;
            r_retries    <= w_retries_nx;
            r_wait       <= w_wait_nx;
            r_sfail      <= w_sfail_nx;
            r_rstall     <= w_rstall_nx;
            r_ever_moved <= w_ever_nx;
`ifdef ANGLE_SERVO_HAMMER_EN
            r_hammer_left <= w_hammer_nx;
`endif
        end
    end

    // Stall watchdog: counts driven cycles since the encoder last changed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_stall_cnt  <= '0;
            r_prev_angle <= '0;
        end else begin
            r_prev_angle <= current_angle;
            if (!is_run_state(r_state) || w_moved)
                r_stall_cnt <= '0;
            else
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Next-state and ratio sequencing; abort beats a simultaneous update.
    always_comb begin
        w_state_nx   = r_state;
        w_target_nx  = r_target;
        w_dir_nx     = r_dir;
        w_ratio_nx   = r_ratio;
        w_upd_nx     = 1'b0;
        w_pending_nx = r_pending && !pwm_done;
        w_retries_nx = r_retries;
        w_wait_nx    = '0;
        w_sfail_nx   = r_sfail;
        w_rstall_nx  = r_rstall;
        w_ever_nx    = r_ever_moved || w_moved;
`ifdef ANGLE_SERVO_HAMMER_EN
        w_hammer_nx  = r_hammer_left;
`endif
        if (abort_angle) begin
            w_state_nx = IDLE;
        end else if (angle_update) begin
            // Fresh moves start at the floor; re-latching mid-move keeps the ratio.
            w_state_nx   = CALC;
            w_target_nx  = target_angle;
            w_retries_nx = retry_count;
            w_sfail_nx   = 1'b0;
            w_rstall_nx  = 1'b0;
            w_ever_nx    = 1'b0;
            if (r_state == IDLE)
                w_ratio_nx = c_min;
        end else begin
            case (r_state)
                IDLE: begin
                end
                CALC: begin
                    w_dir_nx = w_err_dir;
                    if (w_err_mag <= c_tol) begin
                        w_state_nx = DONE;
`ifdef ANGLE_SERVO_HAMMER_EN
                    end else if (hammer_count != 4'd0) begin
                        w_state_nx  = HAMMER;
                        w_hammer_nx = hammer_count;
`endif
                    end else begin
                        w_state_nx = ACCEL;
                        if (w_can_step) begin
                            w_upd_nx     = 1'b1;
                            w_pending_nx = 1'b1;
                        end
                    end
                end
                RETRY: begin
                    if (r_wait == c_retry_last) begin
                        w_state_nx   = CALC;
                        w_retries_nx = r_retries - 2'd1;
                    end else begin
                        w_wait_nx = r_wait + 10'd1;
                    end
                end
                DONE, FAIL: begin
                    w_state_nx = IDLE;
                end
                default: begin
                    if (w_err_mag <= c_tol) begin
                        w_state_nx = DONE;
                    end else if (w_stall) begin
                        if (r_retries != 2'd0) begin
                            w_state_nx = RETRY;
                            w_ratio_nx = c_min;
                        end else begin
                            w_state_nx  = FAIL;
                            w_sfail_nx  = !r_ever_moved;
                            w_rstall_nx = r_ever_moved;
                        end
                    end else if (r_state == ACCEL) begin
                        if (w_err_mag < c_decel) begin
                            w_state_nx = DECEL;
                        end else if (w_can_step) begin
                            if (r_ratio >= c_max) begin
                                w_state_nx = CRUISE;
                            end else begin
                                w_ratio_nx   = w_ratio_up;
                                w_upd_nx     = 1'b1;
                                w_pending_nx = 1'b1;
                            end
                        end
                    end else if (r_state == CRUISE) begin
                        if (w_err_mag < c_decel)
                            w_state_nx = DECEL;
                    end else if (r_state == DECEL) begin
                        if (w_can_step && (r_ratio > c_min)) begin
                            w_ratio_nx   = w_ratio_dn;
                            w_upd_nx     = 1'b1;
                            w_pending_nx = 1'b1;
                        end
`ifdef ANGLE_SERVO_HAMMER_EN
                    end else if (r_state == HAMMER) begin
                        if (w_can_step) begin
                            w_upd_nx     = 1'b1;
                            w_pending_nx = 1'b1;
                            if (r_hammer_left == 4'd0) begin
                                w_state_nx = ACCEL;
                                w_ratio_nx = c_min;
                            end else begin
                                w_ratio_nx  = c_max;
                                w_hammer_nx = r_hammer_left - 4'd1;
                            end
                        end
`endif
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        pwm_enable    = is_run_state(r_state);
        pwm_update    = r_upd;
        pwm_ratio     = r_ratio;
        pwm_direction = r_dir;
        angle_done    = (r_state == DONE);
        startup_fail  = r_sfail;
        run_stall     = r_rstall;
    end

endmodule
`default_nettype wire

// File: tb/tb_angle_servo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_angle_servo_ctrl
// Brief    : Directed self-checking bench for angle_servo_ctrl with a small
//            PWM responder acknowledging every ratio update.
// Config   : ANGLE_SERVO_HAMMER_EN - expects the hammer pulses in the
//            forward move.
// Revision : 1.0 - initial release
// ============================================================================
module tb_angle_servo_ctrl;
    import angle_servo_pkg::*;

`ifdef ANGLE_SERVO_HAMMER_EN
    localparam int H = 3;
`else
    localparam int H = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [11:0] target_angle, current_angle;
    logic        angle_update, abort_angle, pwm_done;
    logic [3:0]  ramp_step, hammer_count;
    logic [1:0]  retry_count;
    logic        pwm_enable, pwm_update, pwm_direction, angle_done, startup_fail, run_stall;
    logic [7:0]  pwm_ratio;

    int n_vec = 0;
    int n_err = 0;
    int cur, upd_n, acc_bad, stable_bad, dir_bad, done_n, after, falls, hold;
    logic [11:0] done_at;
    logic [7:0]  last_ratio, prev_ratio;
    logic        prev_en;

    angle_servo_ctrl #(.STALL_CYCLES(200)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .target_angle  (target_angle),
        .current_angle (current_angle),
        .angle_update  (angle_update),
        .abort_angle   (abort_angle),
        .ramp_step     (ramp_step),
        .retry_count   (retry_count),
        .hammer_count  (hammer_count),
        .pwm_done      (pwm_done),
        .pwm_enable    (pwm_enable),
        .pwm_update    (pwm_update),
        .pwm_ratio     (pwm_ratio),
        .pwm_direction (pwm_direction),
        .angle_done    (angle_done),
        .startup_fail  (startup_fail),
        .run_stall     (run_stall)
    );

    always #5 clock = ~clock;

    // PWM model: acknowledge each update three cycles later.
    initial begin
        pwm_done = 1'b0;
        forever begin
            @(negedge clock);
            while (pwm_update) begin
                repeat (2) @(negedge clock);
                pwm_done = 1'b1;
                @(negedge clock);
                pwm_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_update(input logic [11:0] tgt, input logic [11:0] cur_a);
        target_angle  = tgt;
        current_angle = cur_a;
        angle_update  = 1'b1;
        @(negedge clock);
        angle_update  = 1'b0;
    endtask

    task automatic do_abort();
        abort_angle = 1'b1;
        @(negedge clock);
        abort_angle = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; target_angle = '0; current_angle = '0; angle_update = 1'b0;
        abort_angle = 1'b0; ramp_step = 4'd4; retry_count = 2'd1; hammer_count = 4'd3;
        repeat (3) @(negedge clock);
        check("rst_enable", pwm_enable, 0);
        check("rst_update", pwm_update, 0);
        check("rst_ratio", pwm_ratio, 0);
        check("rst_dir", pwm_direction, 0);
        check("rst_done", angle_done, 0);
        check("rst_sfail", startup_fail, 0);
        check("rst_rstall", run_stall, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Already within tolerance: straight to DONE without driving.
        pulse_update(12'd11, 12'd10);
        @(negedge clock);
        check("tol_done_pulse", angle_done, 1);
        check("tol_enable", pwm_enable, 0);
        @(negedge clock);
        check("tol_done_once", angle_done, 0);

        // Wrap-around and half-circle boundary.
        pulse_update(12'd10, 12'd4090);
        check("wrap_fwd_mag", dut.w_err_mag, 16);
        @(negedge clock);
        check("wrap_fwd_dir", pwm_direction, 1);
        do_abort();
        pulse_update(12'd4090, 12'd10);
        check("wrap_rvs_mag", dut.w_err_mag, 16);
        @(negedge clock);
        check("wrap_rvs_dir", pwm_direction, 0);
        do_abort();
        pulse_update(12'd2048, 12'd0);
        check("half_mag", dut.w_err_mag, 2048);
        @(negedge clock);
        check("half_dir", pwm_direction, 1);
        do_abort();
        pulse_update(12'd2049, 12'd0);
        check("over_half_mag", dut.w_err_mag, 2047);
        @(negedge clock);
        check("over_half_dir", pwm_direction, 0);
        do_abort();

        // Forward move 10 -> 100, encoder advancing every 20 cycles.
        cur = 10;
        pulse_update(12'd100, 12'd10);
        upd_n = 0; acc_bad = 0; stable_bad = 0; dir_bad = 0; done_n = 0; after = 0;
        done_at = '0; last_ratio = '0; prev_ratio = '0; prev_en = 1'b0;
        for (int c = 0; c < 4000 && after < 30; c++) begin
            @(negedge clock);
            if (pwm_enable && prev_en && !pwm_update && pwm_ratio !== prev_ratio) stable_bad++;
            if (pwm_enable && pwm_direction !== 1'b1) dir_bad++;
            if (pwm_update) begin
                if (upd_n < H) begin
                    if (pwm_ratio !== 8'd240) acc_bad++;
                end else if (upd_n < H + 51) begin
                    if (pwm_ratio !== 8'(40 + 4 * (upd_n - H))) acc_bad++;
                end
                upd_n++;
                last_ratio = pwm_ratio;
            end
            if (angle_done) begin
                done_n++;
                done_at = current_angle;
            end
            if (done_n != 0) after++;
            prev_en = pwm_enable;
            prev_ratio = pwm_ratio;
            if (c % 20 == 19 && done_n == 0 && cur < 100) begin
                cur++;
                current_angle = 12'(cur);
            end
        end
        check("fwd_done_count", done_n, 1);
        check("fwd_done_at", done_at, 98);
        check("fwd_direction", dir_bad, 0);
        check("fwd_ramp_values", acc_bad, 0);
        check("fwd_update_count", upd_n, 101 + H);
        check("fwd_final_ratio", last_ratio, 40);
        check("fwd_ratio_stable", stable_bad, 0);
        check("fwd_enable_after", pwm_enable, 0);

        // Abort collides with an update while cruising.
        hammer_count = 4'd0;
        cur = 10;
        pulse_update(12'd1000, 12'd10);
        hold = 0;
        for (int c = 0; c < 1500 && hold < 6; c++) begin
            @(negedge clock);
            if (pwm_ratio == 8'd240) hold++;
            if (c % 20 == 19) begin
                cur++;
                current_angle = 12'(cur);
            end
        end
        check("abort_pre_cruise", 32'(dut.r_state), 32'(CRUISE));
        check("abort_pre_enable", pwm_enable, 1);
        abort_angle = 1'b1; angle_update = 1'b1; target_angle = 12'd50;
        @(negedge clock);
        abort_angle = 1'b0; angle_update = 1'b0;
        check("abort_enable_next", pwm_enable, 0);
        check("abort_state_idle", 32'(dut.r_state), 32'(IDLE));
        repeat (5) @(negedge clock);
        check("abort_stays_idle", 32'(dut.r_state), 32'(IDLE));

        // Startup failure: encoder never moves, two retries.
        retry_count = 2'd2;
        pulse_update(12'd100, 12'd10);
        falls = 0; done_n = 0; prev_en = 1'b0;
        for (int c = 0; c < 6000 && !startup_fail; c++) begin
            @(negedge clock);
            if (prev_en && !pwm_enable) falls++;
            if (angle_done) done_n++;
            prev_en = pwm_enable;
        end
        check("sfail_flag", startup_fail, 1);
        check("sfail_windows", falls, 3);
        check("sfail_rstall", run_stall, 0);
        check("sfail_no_done", done_n, 0);

        // Run stall: move 20 counts then freeze, no retries.
        retry_count = 2'd0;
        cur = 10;
        pulse_update(12'd100, 12'd10);
        check("update_clears_sfail", startup_fail, 0);
        done_n = 0;
        for (int c = 0; c < 3000 && !run_stall; c++) begin
            @(negedge clock);
            if (angle_done) done_n++;
            if (c % 20 == 19 && cur < 30) begin
                cur++;
                current_angle = 12'(cur);
            end
        end
        check("rstall_flag", run_stall, 1);
        check("rstall_sfail", startup_fail, 0);
        check("rstall_no_done", done_n, 0);

        // Reset clears sticky flags and a move in progress.
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("rst_clears_rstall", run_stall, 0);
        @(negedge clock);
        pulse_update(12'd600, 12'd30);
        repeat (100) @(negedge clock);
        check("midmove_enable_pre", pwm_enable, 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("midmove_enable", pwm_enable, 0);
        check("midmove_ratio", pwm_ratio, 0);
        check("midmove_dir", pwm_direction, 0);
        check("midmove_state", 32'(dut.r_state), 32'(IDLE));
        reset_n = 1'b1;
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
